lanzones_fetch: RTL and testbench

Instruction-fetch stage of the lanzones RISC-V pipeline. Generates the sequential program counter and issues word reads to instruction memory over a valid/ready request channel. Accepts in-order read responses into a DEPTH-entry prefetch FIFO and presents {pc, instruction} pairs to the decode stage over a valid/ready channel. Handles redirects (branch/jump/trap) by flushing buffered instructions and discarding responses still in flight.

---
 rtl/lanzones_fetch.sv | 160 ++++++++++++++++
 tb/tb_lanzones_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lanzones_fetch.sv
// Instruction-fetch stage: sequential PC generation, credit-limited word reads to
// instruction memory, a DEPTH-entry prefetch FIFO, and redirect flush/discard.
module lanzones_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        req_vld,
  output logic [31:0] req_addr,
  input  logic        req_rdy,
  input  logic        rsp_vld,
  input  logic [31:0] rsp_data,
  output logic        inst_vld,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_rdy,
  input  logic        redir_vld,
  input  logic [31:0] redir_pc
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [31:0]   fifo_pc_d [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_data_d [DEPTH];

  logic [31:0]   redir_tgt_s;
  logic [CW:0]   credit_used_s;
  logic          credit_ok_s;
  logic          req_fire_s;
  logic          rsp_take_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] wr_idx_s;

  // Outstanding reads plus buffered entries never exceed DEPTH, so unstallable
  // responses always find room in the FIFO.
  assign redir_tgt_s   = redir_pc & 32'hFFFF_FFFC;
  assign credit_used_s = {1'b0, outstanding_q} + {1'b0, count_q};
  assign credit_ok_s   = credit_used_s < (CW+1)'(DEPTH);

  assign req_vld   = rstn && !redir_vld && credit_ok_s;
  assign req_addr  = fetch_pc_q;
  assign inst_vld  = rstn && !redir_vld && (count_q != CNT_ZERO);
  // Slot 0 is always the FIFO head, so decode sees flop outputs directly.
  assign inst_pc   = fifo_pc_q[0];
  assign inst_data = fifo_data_q[0];

  assign req_fire_s = req_vld && req_rdy;
  assign rsp_take_s = rsp_vld && (outstanding_q != CNT_ZERO);
  assign push_s     = rsp_take_s && !redir_vld && (drop_cnt_q == CNT_ZERO);
  assign pop_s      = inst_vld && inst_rdy;
  assign wr_idx_s   = count_q - (pop_s ? CNT_ONE : CNT_ZERO);

  // Next-state for PCs and the request/discard counters.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    case ({req_fire_s, rsp_take_s})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE;
      default: outstanding_d = outstanding_q;
    endcase

    if (redir_vld) begin
      fetch_pc_d = redir_tgt_s;
      rsp_pc_d   = redir_tgt_s;
      // Everything still in flight belongs to the old path; a response landing
      // this cycle is already accounted for by being dropped here.
      drop_cnt_d = outstanding_q - (rsp_take_s ? CNT_ONE : CNT_ZERO);
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push_s) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end else begin
        rsp_pc_d = rsp_pc_q;
      end
      if (rsp_take_s && (drop_cnt_q != CNT_ZERO)) begin
        drop_cnt_d = drop_cnt_q - CNT_ONE;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // Next-state for the shift-style prefetch FIFO.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      fifo_pc_d[i]   = fifo_pc_q[i];
      fifo_data_d[i] = fifo_data_q[i];
    end

    if (redir_vld) begin
      count_d = CNT_ZERO;
    end else begin
      if (pop_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          fifo_pc_d[i]   = fifo_pc_q[i+1];
          fifo_data_d[i] = fifo_data_q[i+1];
        end
        fifo_pc_d[DEPTH-1]   = 32'h0;
        fifo_data_d[DEPTH-1] = 32'h0;
      end else begin
        count_d = count_q;
      end
      if (push_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          fifo_pc_d[i]   = (CW'(i) == wr_idx_s) ? rsp_pc_q : fifo_pc_d[i];
          fifo_data_d[i] = (CW'(i) == wr_idx_s) ? rsp_data : fifo_data_d[i];
        end
      end else begin
        count_d = count_q;
      end
      count_d = count_q + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= CNT_ZERO;
      drop_cnt_q    <= CNT_ZERO;
      count_q       <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= 32'h0;
        fifo_data_q[i] <= 32'h0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= fifo_pc_d[i];
        fifo_data_q[i] <= fifo_data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_lanzones_fetch.sv
// Bench for lanzones_fetch: a queue-based memory with variable latency, an event
// log of transfers, and a PC-stream model that replays redirects from the log.
module tb_lanzones_fetch;
  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
  localparam int          DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_vld, inst_vld;
  logic [31:0] req_addr, inst_data, inst_pc;
  logic        req_rdy = 1'b0, inst_rdy = 1'b0, redir_vld = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        rsp_vld = 1'b0;
  logic [31:0] rsp_data = 32'h0;

  logic        w_req_vld, w_inst_vld;
  logic [31:0] w_req_addr, w_inst_data, w_inst_pc;
  logic        w_rsp_vld = 1'b0;
  logic [31:0] w_rsp_data = 32'h0;
  logic        w_fire_p = 1'b0;
  logic [31:0] w_addr_p = 32'h0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { int kind; logic [31:0] pc; logic [31:0] data; } ev_t; // 0 inst, 1 redirect, 2 request
  pend_t pend[$];
  ev_t   ev_q[$];
  int    cyc = 0, lat = 1, viol = 0;
  int    checks = 0, passed = 0;

  lanzones_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .req_vld(req_vld), .req_addr(req_addr), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .inst_vld(inst_vld), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_rdy(inst_rdy), .redir_vld(redir_vld), .redir_pc(redir_pc));

  lanzones_fetch #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rstn(rstn), .req_vld(w_req_vld), .req_addr(w_req_addr), .req_rdy(1'b1),
    .rsp_vld(w_rsp_vld), .rsp_data(w_rsp_data), .inst_vld(w_inst_vld), .inst_data(w_inst_data),
    .inst_pc(w_inst_pc), .inst_rdy(1'b1), .redir_vld(1'b0), .redir_pc(32'h0));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model and transfer log, sampled on the active edge.
  always @(posedge clk) begin
    if (!rstn) begin
      pend.delete();
      w_fire_p = 1'b0;
    end else begin
      if (rsp_vld && pend.size() > 0) void'(pend.pop_front());
      if (req_vld && req_rdy) begin
        pend.push_back('{req_addr, cyc + lat});
        ev_q.push_back('{2, req_addr, 32'h0});
      end
      if (inst_vld && inst_rdy) ev_q.push_back('{0, inst_pc, inst_data});
      if (redir_vld) ev_q.push_back('{1, redir_pc & 32'hFFFF_FFFC, 32'h0});
      if (redir_vld && (req_vld || inst_vld)) viol++;
      if (pend.size() > DEPTH) viol++;
      w_fire_p = w_req_vld;
      w_addr_p = w_req_addr;
    end
    cyc++;
  end

  // Responses are driven on the opposite edge.
  always @(negedge clk) begin
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp_vld  = 1'b1;
      rsp_data = mem_word(pend[0].addr);
    end else begin
      rsp_vld  = 1'b0;
      rsp_data = 32'h0;
    end
    w_rsp_vld  = w_fire_p;
    w_rsp_data = mem_word(w_addr_p);
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    rstn = 1'b0;
    redir_vld = 1'b0;
    repeat (n) @(negedge clk);
    ev_q.delete();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    req_rdy = 1'b1; inst_rdy = 1'b1; lat = 1;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_vld !== 1'b0) $display("FAIL rst_req_vld got %b want 0", req_vld); else passed++;
    checks++; if (req_addr !== RST_PC) $display("FAIL rst_req_addr got %h want %h", req_addr, RST_PC); else passed++;
    checks++; if (inst_vld !== 1'b0) $display("FAIL rst_inst_vld got %b want 0", inst_vld); else passed++;
    checks++; if (inst_data !== 32'h0) $display("FAIL rst_inst_data got %h want 0", inst_data); else passed++;
    checks++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc got %h want 0", inst_pc); else passed++;
    ev_q.delete();
    rstn = 1'b1;
    #1;
    checks++; if (req_vld !== 1'b1) $display("FAIL rel_req_vld got %b want 1", req_vld); else passed++;
    checks++; if (req_addr !== RST_PC) $display("FAIL rel_req_addr got %h want %h", req_addr, RST_PC); else passed++;
  endtask

  task automatic test_straight;
    logic [31:0] e;
    req_rdy = 1'b1; inst_rdy = 1'b1; lat = 1;
    do_reset(2);
    for (int k = 0; k < 8; k++) begin
      e = RST_PC + 32'(4 * k);
      checks++; if (req_vld !== 1'b1 || req_addr !== e)
        $display("FAIL straight_req c%0d got %b/%h want 1/%h", k, req_vld, req_addr, e); else passed++;
      if (k < 2) begin
        checks++; if (inst_vld !== 1'b0) $display("FAIL straight_early c%0d got %b want 0", k, inst_vld); else passed++;
      end else begin
        e = RST_PC + 32'(4 * (k - 2));
        checks++; if (inst_vld !== 1'b1 || inst_pc !== e || inst_data !== mem_word(e))
          $display("FAIL straight_inst c%0d got %b/%h/%h want 1/%h/%h", k, inst_vld, inst_pc, inst_data, e, mem_word(e));
        else passed++;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int nreq, ni;
    logic [31:0] e;
    req_rdy = 1'b1; inst_rdy = 1'b0; lat = 1;
    do_reset(2);
    repeat (8) @(negedge clk);
    #1;
    nreq = 0;
    foreach (ev_q[i]) if (ev_q[i].kind == 2) nreq++;
    checks++; if (nreq != DEPTH) $display("FAIL bp_req_count got %0d want %0d", nreq, DEPTH); else passed++;
    checks++; if (req_vld !== 1'b0) $display("FAIL bp_req_vld got %b want 0", req_vld); else passed++;
    checks++; if (inst_vld !== 1'b1 || inst_pc !== RST_PC)
      $display("FAIL bp_head got %b/%h want 1/%h", inst_vld, inst_pc, RST_PC); else passed++;
    inst_rdy = 1'b1;
    @(negedge clk); #1;
    checks++; if (req_vld !== 1'b1) $display("FAIL bp_credit_back got %b want 1", req_vld); else passed++;
    repeat (6) @(negedge clk);
    #1;
    ni = 0;
    foreach (ev_q[i]) if (ev_q[i].kind == 0 && ni < 4) begin
      e = RST_PC + 32'(4 * ni);
      checks++; if (ev_q[i].pc !== e || ev_q[i].data !== mem_word(e))
        $display("FAIL bp_drain %0d got %h/%h want %h/%h", ni, ev_q[i].pc, ev_q[i].data, e, mem_word(e)); else passed++;
      ni++;
    end
    checks++; if (ni != 4) $display("FAIL bp_drain_count got %0d want 4", ni); else passed++;
  endtask

  task automatic test_stall;
    int nreq, ni;
    req_rdy = 1'b1; inst_rdy = 1'b1; lat = 1;
    do_reset(2);
    repeat (4) @(negedge clk);
    #1;
    req_rdy = 1'b0;
    for (int s = 0; s < 5; s++) begin
      checks++; if (req_vld !== 1'b1 || req_addr !== RST_PC + 32'h10)
        $display("FAIL stall_hold s%0d got %b/%h want 1/%h", s, req_vld, req_addr, RST_PC + 32'h10); else passed++;
      @(negedge clk); #1;
    end
    nreq = 0; ni = 0;
    foreach (ev_q[i]) begin
      if (ev_q[i].kind == 2) nreq++;
      if (ev_q[i].kind == 0) ni++;
    end
    checks++; if (nreq != 4) $display("FAIL stall_reqs got %0d want 4", nreq); else passed++;
    checks++; if (ni != 4) $display("FAIL stall_insts got %0d want 4", ni); else passed++;
    checks++; if (inst_vld !== 1'b0) $display("FAIL stall_drained got %b want 0", inst_vld); else passed++;
    req_rdy = 1'b1;
  endtask

  task automatic test_redirect;
    logic [31:0] e;
    int ni;
    req_rdy = 1'b1; inst_rdy = 1'b1; lat = 3;
    do_reset(2);
    repeat (3) @(negedge clk);
    redir_vld = 1'b1; redir_pc = 32'h0000_2003;
    #1;
    checks++; if (req_vld !== 1'b0 || inst_vld !== 1'b0)
      $display("FAIL redir_quiet got %b/%b want 0/0", req_vld, inst_vld); else passed++;
    @(negedge clk);
    redir_vld = 1'b0;
    #1;
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'h0000_2000)
      $display("FAIL redir_target got %b/%h want 1/00002000", req_vld, req_addr); else passed++;
    repeat (15) @(negedge clk);
    #1;
    e = 32'h0000_2000; ni = 0;
    foreach (ev_q[i]) if (ev_q[i].kind == 0) begin
      checks++; if (ev_q[i].pc !== e || ev_q[i].data !== mem_word(e))
        $display("FAIL redir_stream %0d got %h/%h want %h/%h", ni, ev_q[i].pc, ev_q[i].data, e, mem_word(e)); else passed++;
      e += 32'd4; ni++;
    end
    checks++; if (ni < 5) $display("FAIL redir_progress got %0d want >=5", ni); else passed++;
  endtask

  task automatic test_wrap;
    lat = 1;
    do_reset(2);
    checks++; if (w_req_vld !== 1'b1 || w_req_addr !== WRAP_PC)
      $display("FAIL wrap_req0 got %b/%h want 1/%h", w_req_vld, w_req_addr, WRAP_PC); else passed++;
    @(negedge clk); #1;
    checks++; if (w_req_addr !== 32'h0) $display("FAIL wrap_req1 got %h want 0", w_req_addr); else passed++;
    @(negedge clk); #1;
    checks++; if (w_inst_vld !== 1'b1 || w_inst_pc !== WRAP_PC || w_inst_data !== mem_word(WRAP_PC))
      $display("FAIL wrap_inst0 got %b/%h/%h want 1/%h", w_inst_vld, w_inst_pc, w_inst_data, WRAP_PC); else passed++;
    @(negedge clk); #1;
    checks++; if (w_inst_vld !== 1'b1 || w_inst_pc !== 32'h0 || w_inst_data !== mem_word(32'h0))
      $display("FAIL wrap_inst1 got %b/%h/%h want 1/0", w_inst_vld, w_inst_pc, w_inst_data); else passed++;
  endtask

  task automatic test_reset_mid;
    int ni;
    req_rdy = 1'b1; inst_rdy = 1'b0; lat = 3;
    do_reset(2);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if (req_vld !== 1'b0 || inst_vld !== 1'b0)
      $display("FAIL mid_rst_comb got %b/%b want 0/0", req_vld, inst_vld); else passed++;
    @(negedge clk); #1;
    checks++; if (inst_vld !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0 || req_addr !== RST_PC)
      $display("FAIL mid_rst_regs got %b/%h/%h/%h want 0/0/0/%h", inst_vld, inst_pc, inst_data, req_addr, RST_PC);
    else passed++;
    ev_q.delete();
    lat = 1; inst_rdy = 1'b1; rstn = 1'b1;
    #1;
    checks++; if (req_vld !== 1'b1 || req_addr !== RST_PC)
      $display("FAIL mid_restart got %b/%h want 1/%h", req_vld, req_addr, RST_PC); else passed++;
    repeat (6) @(negedge clk);
    #1;
    ni = 0;
    foreach (ev_q[i]) if (ev_q[i].kind == 0) begin
      if (ni == 0) begin
        checks++; if (ev_q[i].pc !== RST_PC) $display("FAIL mid_first_pc got %h want %h", ev_q[i].pc, RST_PC); else passed++;
      end
      ni++;
    end
    checks++; if (ni < 3) $display("FAIL mid_progress got %0d want >=3", ni); else passed++;
  endtask

  task automatic test_random;
    logic [31:0] exp_i, exp_r;
    int ni, bad;
    logic prev_redir;
    req_rdy = 1'b1; inst_rdy = 1'b1; lat = 1;
    do_reset(2);
    viol = 0;
    prev_redir = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      req_rdy  = ($urandom_range(0, 3) != 0);
      inst_rdy = ($urandom_range(0, 9) < 7);
      lat      = $urandom_range(1, 3);
      if (!prev_redir && $urandom_range(0, 14) == 0) begin
        redir_vld = 1'b1;
        redir_pc  = $urandom;
      end else begin
        redir_vld = 1'b0;
      end
      prev_redir = redir_vld;
    end
    @(negedge clk);
    redir_vld = 1'b0; req_rdy = 1'b1; inst_rdy = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    exp_i = RST_PC; exp_r = RST_PC; ni = 0; bad = 0;
    foreach (ev_q[i]) begin
      case (ev_q[i].kind)
        1: begin exp_i = ev_q[i].pc; exp_r = ev_q[i].pc; end
        2: begin
          checks++;
          if (ev_q[i].pc !== exp_r) begin
            if (bad < 10) $display("FAIL rnd_req ev%0d got %h want %h", i, ev_q[i].pc, exp_r);
            bad++;
          end else passed++;
          exp_r += 32'd4;
        end
        default: begin
          checks++;
          if (ev_q[i].pc !== exp_i || ev_q[i].data !== mem_word(exp_i)) begin
            if (bad < 10) $display("FAIL rnd_inst ev%0d got %h/%h want %h/%h", i, ev_q[i].pc, ev_q[i].data, exp_i, mem_word(exp_i));
            bad++;
          end else passed++;
          exp_i += 32'd4; ni++;
        end
      endcase
    end
    checks++; if (viol != 0) $display("FAIL rnd_protocol got %0d violations want 0", viol); else passed++;
    checks++; if (ni < 40) $display("FAIL rnd_progress got %0d insts want >=40", ni); else passed++;
  endtask

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
